// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
//   Definitions shared by the SDRAM controller wrapper and its multi-port
//   arbiter front end.
//   - DEF_HADDR_WIDTH / DEF_DATA_WIDTH : default host address / data widths
//   - arb_state_t                      : arbiter FSM state encoding
//   - idx_width()                      : index width for a port count (min 1)
// -----------------------------------------------------------------------------
package sdram_pkg;

  // Host address is bank + row + column.
  localparam int DEF_HADDR_WIDTH = 24;
  localparam int DEF_DATA_WIDTH  = 16;

  // Widest read latency the latency tracker has to count.
  localparam int MAX_RD_LATENCY  = 14;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,  // pick a requester
    ST_ISSUE = 2'd1,  // command pulse on the controller host side
    ST_GAP   = 2'd2   // let the controller finish before the next command
  } arb_state_t;

  // Bits needed to index n ports; never returns 0 so vectors stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// -----------------------------------------------------------------------------
// sdram_arbiter_if
//   Bundles the requester side and the controller host side of the arbiter.
//   Requester side : req, we, addr, wdata (in to arbiter), gnt, rvalid, rdata
//   Controller side: haddr, data_input, rd_enable, wr_enable (out of arbiter),
//                    busy, data_output (in to arbiter)
//   Per-port fields are packed, port k at [k*W +: W].
//   Modports: slave  - the arbiter
//             master - the environment (requesters + controller)
// -----------------------------------------------------------------------------
interface sdram_arbiter_if #(
  parameter int NPORTS      = 4,
  parameter int HADDR_WIDTH = sdram_pkg::DEF_HADDR_WIDTH,
  parameter int DATA_WIDTH  = sdram_pkg::DEF_DATA_WIDTH
);

  // Requester side
  logic [NPORTS-1:0]             req;
  logic [NPORTS-1:0]             we;
  logic [NPORTS*HADDR_WIDTH-1:0] addr;
  logic [NPORTS*DATA_WIDTH-1:0]  wdata;
  logic [NPORTS-1:0]             gnt;
  logic [NPORTS-1:0]             rvalid;
  logic [DATA_WIDTH-1:0]         rdata;

  // Controller host side
  logic [HADDR_WIDTH-1:0]        haddr;
  logic [DATA_WIDTH-1:0]         data_input;
  logic                          rd_enable;
  logic                          wr_enable;
  logic                          busy;
  logic [DATA_WIDTH-1:0]         data_output;

  modport slave (
    input  req, we, addr, wdata, busy, data_output,
    output gnt, rvalid, rdata, haddr, data_input, rd_enable, wr_enable
  );

  modport master (
    output req, we, addr, wdata, busy, data_output,
    input  gnt, rvalid, rdata, haddr, data_input, rd_enable, wr_enable
  );

endinterface

// File: rtl/sdram_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick: the first set bit of req scanning from
//   index ptr upward, wrapping modulo NPORTS.
//   Ports:
//     req        in  NPORTS  request vector
//     ptr        in  IDX_W   highest-priority index for this pick
//     win_onehot out NPORTS  one-hot winner (0 when no request)
//     win_idx    out IDX_W   winner index (0 when no request)
//     win_valid  out 1       any request present
// -----------------------------------------------------------------------------
module rr_arbiter
  import sdram_pkg::*;
#(
  parameter  int NPORTS = 4,
  localparam int IDX_W  = idx_width(NPORTS)
) (
  input  logic [NPORTS-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NPORTS-1:0] win_onehot,
  output logic [IDX_W-1:0]  win_idx,
  output logic              win_valid
);

  // (base + off) mod NPORTS for off in 0..NPORTS-1 and base < NPORTS.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int               off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NPORTS) sum = sum - NPORTS;
    return IDX_W'(sum);
  endfunction

  logic [IDX_W-1:0] cand;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; otherwise synthesis infers a latch.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NPORTS; i++) begin
      cand = wrap_add(ptr, i);
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
    win_onehot = win_valid ? (NPORTS'(1) << win_idx) : '0;
  end

endmodule

// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
//   Shares the single-port SDRAM controller host interface among NPORTS
//   requesters with round-robin arbitration. Each command is a single-cycle
//   rd_enable/wr_enable pulse followed by CMD_GAP idle cycles, so the
//   controller always finishes one operation before the next is issued.
//   Read data is registered into rdata RD_LATENCY cycles after the read pulse
//   and tagged to the originating port with a one-cycle rvalid bit.
//
//   Parameters:
//     NPORTS      2..8 requesters
//     HADDR_WIDTH host address width
//     DATA_WIDTH  data width
//     RD_LATENCY  1..14, enable pulse to controller read data
//     CMD_GAP     idle cycles after each issue; must be >= RD_LATENCY and
//                 cover a full controller write sequence
//   Ports:
//     clk   in  single clock
//     rst   in  synchronous, active-high reset
//     bus   slave modport of sdram_arbiter_if (requesters + controller)
//
//   Timing: req seen in ARB at cycle T -> gnt/enable at T+1; read result at
//   T+1+RD_LATENCY. Enable pulses are at least CMD_GAP+2 cycles apart.
// -----------------------------------------------------------------------------
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int NPORTS      = 4,
  parameter int HADDR_WIDTH = DEF_HADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int RD_LATENCY  = 4,
  parameter int CMD_GAP     = 10
) (
  input  logic           clk,
  input  logic           rst,
  sdram_arbiter_if.slave bus
);

  localparam int IDX_W = idx_width(NPORTS);
  localparam int GAP_W = $clog2(CMD_GAP + 1);
  localparam int LAT_W = $clog2(MAX_RD_LATENCY + 1);

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;        // highest-priority port for the next pick
  logic [IDX_W-1:0] win_idx_q;  // port being issued
  logic [GAP_W-1:0] gap_cnt;

  // Read-return tracker. Only one read can be in flight because the gap
  // after every issue is at least as long as the read latency.
  logic             rd_pend;
  logic [LAT_W-1:0] lat_cnt;
  logic [IDX_W-1:0] rd_tag;

  logic [NPORTS-1:0] arb_onehot;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_valid;

  rr_arbiter #(
    .NPORTS (NPORTS)
  ) u_rr (
    .req        (bus.req),
    .ptr        (ptr),
    .win_onehot (arb_onehot),
    .win_idx    (arb_idx),
    .win_valid  (arb_valid)
  );

  // Pointer moves to the port after the one just served.
  logic [IDX_W-1:0] ptr_next;
  assign ptr_next = (win_idx_q == IDX_W'(NPORTS - 1)) ? '0 : win_idx_q + 1'b1;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_ARB;
      ptr            <= '0;
      win_idx_q      <= '0;
      gap_cnt        <= '0;
      rd_pend        <= 1'b0;
      lat_cnt        <= '0;
      rd_tag         <= '0;
      bus.gnt        <= '0;
      bus.rvalid     <= '0;
      bus.rdata      <= '0;
      bus.haddr      <= '0;
      bus.data_input <= '0;
      bus.rd_enable  <= 1'b0;
      bus.wr_enable  <= 1'b0;
    end else begin
      // Strobes are single-cycle: cleared every edge unless set below.
      bus.gnt       <= '0;
      bus.rvalid    <= '0;
      bus.rd_enable <= 1'b0;
      bus.wr_enable <= 1'b0;

      // Read return runs independently of the issue FSM.
      if (rd_pend) begin
        if (lat_cnt == LAT_W'(1)) begin
          rd_pend    <= 1'b0;
          bus.rdata  <= bus.data_output;
          bus.rvalid <= NPORTS'(1) << rd_tag;
        end else begin
          lat_cnt <= lat_cnt - 1'b1;
        end
      end

      case (state)
        ST_ARB: begin
          // Outputs for the ISSUE cycle are loaded on the way in, so the
          // enable, gnt, haddr and data_input all come straight from flops.
          if (!bus.busy && arb_valid) begin
            win_idx_q      <= arb_idx;
            bus.gnt        <= arb_onehot;
            bus.haddr      <= bus.addr[int'(arb_idx)*HADDR_WIDTH +: HADDR_WIDTH];
            bus.data_input <= bus.wdata[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
            if (bus.we[arb_idx]) begin
              bus.wr_enable <= 1'b1;
            end else begin
              bus.rd_enable <= 1'b1;
              rd_pend       <= 1'b1;
              lat_cnt       <= LAT_W'(RD_LATENCY);
              rd_tag        <= arb_idx;
            end
            state <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          ptr     <= ptr_next;
          gap_cnt <= GAP_W'(CMD_GAP - 1);
          state   <= ST_GAP;
        end

        ST_GAP: begin
          // Requests are deliberately ignored until the gap has elapsed.
          if (gap_cnt == '0) begin
            state <= ST_ARB;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end

        default: state <= ST_ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_arbiter
//   Directed bench for sdram_arbiter. Each request pushes its expected issue
//   (and read return) onto scoreboard queues; a negedge monitor pops and
//   compares whenever the DUT pulses gnt/enable or rvalid. The controller
//   model returns haddr[15:0] as read data.
// -----------------------------------------------------------------------------
module tb_sdram_arbiter;
  import sdram_pkg::*;

  localparam int NP  = 4;
  localparam int AW  = 24;
  localparam int DW  = 16;
  localparam int RL  = 4;
  localparam int GAP = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdram_arbiter_if #(.NPORTS(NP), .HADDR_WIDTH(AW), .DATA_WIDTH(DW)) arb_if ();

  sdram_arbiter #(
    .NPORTS      (NP),
    .HADDR_WIDTH (AW),
    .DATA_WIDTH  (DW),
    .RD_LATENCY  (RL),
    .CMD_GAP     (GAP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (arb_if.slave)
  );

  // Cycle counter: value n is visible from just after posedge n.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: read data appears once the read pulse is seen.
  logic [DW-1:0] model_q = 16'hDEAD;
  always @(negedge clk) if (arb_if.rd_enable === 1'b1) model_q <= arb_if.haddr[DW-1:0];
  assign arb_if.data_output = model_q;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int          cyc;
    int          port;
    logic        we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t iss_q[$];
  exp_t rv_q[$];
  exp_t ie;
  exp_t re;

  task automatic push_issue(input int c, input int p, input logic w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
    iss_q.push_back('{cyc: c, port: p, we: w, addr: a, data: d});
  endtask

  // Expected read return: model echoes the low address bits.
  task automatic push_rv(input int c, input int p, input logic [AW-1:0] a);
    rv_q.push_back('{cyc: c + RL, port: p, we: 1'b0, addr: a, data: a[DW-1:0]});
  endtask

  task automatic set_port(input int p, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    arb_if.we[p]            = w;
    arb_if.addr[p*AW +: AW] = a;
    arb_if.wdata[p*DW +: DW] = d;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor, sampling on the inactive edge.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (arb_if.gnt !== '0 || arb_if.rd_enable !== 1'b0 || arb_if.wr_enable !== 1'b0) begin
        if (iss_q.size() == 0) begin
          check("unexpected_issue", 32'({arb_if.gnt, arb_if.rd_enable, arb_if.wr_enable}), 32'd0);
        end else begin
          ie = iss_q.pop_front();
          check("issue_cycle", 32'(cyc), 32'(ie.cyc));
          check("issue_gnt", 32'(arb_if.gnt), 32'(1) << ie.port);
          check("issue_enables", 32'({arb_if.wr_enable, arb_if.rd_enable}),
                ie.we ? 32'd2 : 32'd1);
          check("issue_haddr", 32'(arb_if.haddr), 32'(ie.addr));
          if (ie.we) check("issue_wdata", 32'(arb_if.data_input), 32'(ie.data));
        end
      end
      if (arb_if.rvalid !== '0) begin
        if (rv_q.size() == 0) begin
          check("unexpected_rvalid", 32'(arb_if.rvalid), 32'd0);
        end else begin
          re = rv_q.pop_front();
          check("rvalid_cycle", 32'(cyc), 32'(re.cyc));
          check("rvalid_port", 32'(arb_if.rvalid), 32'(1) << re.port);
          check("rdata", 32'(arb_if.rdata), 32'(re.data));
        end
      end
    end
  end

  int n;

  initial begin
    arb_if.req   = '0;
    arb_if.we    = '0;
    arb_if.addr  = '0;
    arb_if.wdata = '0;
    arb_if.busy  = 1'b0;

    // Reset values.
    tick(3);
    check("rst_gnt",        32'(arb_if.gnt), 32'd0);
    check("rst_rvalid",     32'(arb_if.rvalid), 32'd0);
    check("rst_rd_enable",  32'(arb_if.rd_enable), 32'd0);
    check("rst_wr_enable",  32'(arb_if.wr_enable), 32'd0);
    check("rst_haddr",      32'(arb_if.haddr), 32'd0);
    check("rst_data_input", 32'(arb_if.data_input), 32'd0);
    check("rst_rdata",      32'(arb_if.rdata), 32'd0);
    rst = 1'b0;

    // Idle for 50 cycles with no requests.
    for (int i = 0; i < 50; i++) begin
      tick(1);
      check("idle_strobes",
            32'({arb_if.gnt, arb_if.rvalid, arb_if.rd_enable, arb_if.wr_enable}), 32'd0);
    end
    check("idle_haddr", 32'(arb_if.haddr), 32'd0);
    check("idle_rdata", 32'(arb_if.rdata), 32'd0);

    // Port 2 single write.
    set_port(2, 1'b1, 24'h012345, 16'hBEEF);
    push_issue(cyc + 1, 2, 1'b1, 24'h012345, 16'hBEEF);
    arb_if.req[2] = 1'b1;
    tick(1);
    arb_if.req[2] = 1'b0;
    tick(GAP + 4);

    // Port 1 read returning 0xA55A.
    set_port(1, 1'b0, 24'h00A55A, 16'h0000);
    push_issue(cyc + 1, 1, 1'b0, 24'h00A55A, 16'h0000);
    push_rv(cyc + 1, 1, 24'h00A55A);
    arb_if.req[1] = 1'b1;
    tick(1);
    arb_if.req[1] = 1'b0;
    tick(GAP + 4);

    // Port 3 read returning 0x1234.
    set_port(3, 1'b0, 24'h561234, 16'h0000);
    push_issue(cyc + 1, 3, 1'b0, 24'h561234, 16'h0000);
    push_rv(cyc + 1, 3, 24'h561234);
    arb_if.req[3] = 1'b1;
    tick(1);
    arb_if.req[3] = 1'b0;
    tick(GAP + 4);

    // Port 0 write; rdata must keep the last read result.
    set_port(0, 1'b1, 24'hFFFFFF, 16'h8001);
    push_issue(cyc + 1, 0, 1'b1, 24'hFFFFFF, 16'h8001);
    arb_if.req[0] = 1'b1;
    tick(1);
    arb_if.req[0] = 1'b0;
    tick(GAP + 4);
    check("rdata_hold", 32'(arb_if.rdata), 32'h1234);

    // Busy held for 20 cycles with port 3 requesting a write.
    set_port(3, 1'b1, 24'h777777, 16'h3C3C);
    arb_if.busy   = 1'b1;
    arb_if.req[3] = 1'b1;
    push_issue(cyc + 21, 3, 1'b1, 24'h777777, 16'h3C3C);
    tick(20);
    arb_if.busy = 1'b0;
    tick(1);
    arb_if.req[3] = 1'b0;
    tick(GAP + 4);

    // Reset two cycles after a read issue: the read result is discarded.
    set_port(1, 1'b0, 24'h00FACE, 16'h0000);
    n = cyc;
    push_issue(n + 1, 1, 1'b0, 24'h00FACE, 16'h0000);
    arb_if.req[1] = 1'b1;
    tick(1);
    arb_if.req[1] = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    check("state_after_rst",  32'(dut.state), 32'(ST_ARB));
    check("rvalid_after_rst", 32'(arb_if.rvalid), 32'd0);
    check("rdata_after_rst",  32'(arb_if.rdata), 32'd0);

    // Tie between ports 0 and 2: pointer is back at 0, so port 0 first.
    set_port(0, 1'b1, 24'h0A0A0A, 16'h1111);
    set_port(2, 1'b1, 24'h0B0B0B, 16'h2222);
    n = cyc;
    push_issue(n + 1, 0, 1'b1, 24'h0A0A0A, 16'h1111);
    push_issue(n + 1 + GAP + 2, 2, 1'b1, 24'h0B0B0B, 16'h2222);
    arb_if.req[0] = 1'b1;
    arb_if.req[2] = 1'b1;
    tick(1);
    arb_if.req[0] = 1'b0;
    tick(GAP + 2);
    arb_if.req[2] = 1'b0;
    tick(GAP + 4);

    // All ports requesting continuously from reset: strict rotation.
    rst = 1'b1;
    tick(2);
    set_port(0, 1'b1, 24'h100000, 16'h0F0F);
    set_port(1, 1'b0, 24'h20ABCD, 16'h0000);
    set_port(2, 1'b1, 24'h300000, 16'hF0F0);
    set_port(3, 1'b0, 24'h40C0DE, 16'h0000);
    arb_if.req = '1;
    rst = 1'b0;
    n = cyc;
    for (int k = 0; k < 6; k++) begin
      int p;
      p = k % NP;
      push_issue(n + 1 + k * (GAP + 2), p, arb_if.we[p],
                 arb_if.addr[p*AW +: AW], arb_if.wdata[p*DW +: DW]);
      if (!arb_if.we[p]) push_rv(n + 1 + k * (GAP + 2), p, arb_if.addr[p*AW +: AW]);
    end
    tick(1 + 5 * (GAP + 2));
    arb_if.req = '0;
    tick(GAP + 4 + RL);

    check("issue_queue_drained",  32'(iss_q.size()), 32'd0);
    check("rvalid_queue_drained", 32'(rv_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Multi-port front end for the single-port SDRAM controller: shares its simple host interface (address, write data, read/write enable, busy, read data) among `NPORTS` requesters with round-robin arbitration. It issues single-cycle enable pulses, enforces a fixed command spacing so each operation finishes before the next is issued, and returns read data to the originating port with a per-port valid strobe. It sits between system masters (CPU bus bridge, DMA, video fetch) and the controller's host side.

## Interface
- `NPORTS`, 4, number of requesters (2..8)
- `HADDR_WIDTH`, 24, host address width (bank+row+col)
- `DATA_WIDTH`, 16, data width
- `RD_LATENCY`, 4, cycles from enable pulse to valid controller read data, range 1..14
- `CMD_GAP`, 10, idle cycles after each issue before re-arbitration; must satisfy `CMD_GAP >= RD_LATENCY` and cover a full controller write sequence
- `clk`  in  1  single clock
- `rst`  in  1  synchronous, active-high reset
- `req`  in  NPORTS  per-port request, held until `gnt`
- `we`  in  NPORTS  per-port 1=write, 0=read
- `addr`  in  NPORTS*HADDR_WIDTH  packed per-port addresses, port k at [k*HADDR_WIDTH +: HADDR_WIDTH]
- `wdata`  in  NPORTS*DATA_WIDTH  packed per-port write data
- `gnt`  out  NPORTS  one-hot, one-cycle pulse when port's command is issued
- `rvalid`  out  NPORTS  one-hot, one-cycle pulse when `rdata` holds that port's read result
- `rdata`  out  DATA_WIDTH  shared read data
- `haddr`  out  HADDR_WIDTH  to controller
- `data_input`  out  DATA_WIDTH  to controller
- `rd_enable`, `wr_enable`  out  1  to controller, single-cycle pulses
- `busy`  in  1  from controller
- `data_output`  in  DATA_WIDTH  from controller

## Operation
- FSM states: ARB, ISSUE, GAP. Reset enters ARB.
- ARB: if `busy`=0 and any `req`, select the winner by round robin from pointer `ptr`: the first set `req` at index ptr, ptr+1, ... wrapping mod NPORTS. Latch the winner index, `we`, `addr` and `wdata`; go to ISSUE. If `busy`=1 or no `req`, stay.
- ISSUE (one cycle): drive `rd_enable` or `wr_enable`, `haddr`, `data_input` and `gnt[winner]` from registers. Set `ptr` = winner+1 mod NPORTS. Load the gap counter with CMD_GAP-1; go to GAP.
- GAP: decrement the counter; at 0 return to ARB. Requests are ignored in GAP.
- Read return: on a read ISSUE, load a latency counter with RD_LATENCY and record the port tag. When the counter expires, register `data_output` into `rdata` and pulse `rvalid[tag]`. At most one read is outstanding, guaranteed by `CMD_GAP >= RD_LATENCY`.
- `haddr` and `data_input` hold their last values outside ISSUE. `rdata` holds until the next read return.
- A `req` dropped before `gnt` is not served. Arbitration always uses the current `req` in ARB.

## Timing
- Reset values: `gnt`=0, `rvalid`=0, `rd_enable`=`wr_enable`=0, `haddr`=0, `data_input`=0, `rdata`=0. Also `ptr`=0 and no read pending.
- `req` sampled in ARB at cycle T gives the enable and `gnt` pulse at T+1.
- Read: `rvalid` and `rdata` are valid at T+1+RD_LATENCY.
- Minimum spacing between enable pulses is CMD_GAP+2 cycles.
- With `busy` high in ARB, issue is deferred cycle-by-cycle with no timeout.
- Simultaneous requests are served strictly in rotation. With all ports requesting continuously, each port gets 1 of every NPORTS issues.
- Reset mid-operation: FSM returns to ARB and any pending `rvalid` is discarded. `rst` overrides everything in the same edge.
- `rd_enable` and `wr_enable` are never high together and never high for two consecutive cycles.

## Structure
- Shared package `sdram_pkg`: FSM state typedef (ARB/ISSUE/GAP) and default width constants (HADDR_WIDTH, DATA_WIDTH), shared with the controller wrapper.
- One sub-module, `rr_arbiter`:
  - inputs: `req` vector and `ptr`;
  - outputs: one-hot winner and index;
  - purely combinational.
- The pointer, FSM, gap counter and read-latency tracker live in `sdram_arbiter`.

## Test plan
- Reset release, no requests: all outputs 0 for 50 cycles, no enables.
- Port 2 single write (addr 0x012345, wdata 0xBEEF): `wr_enable`, `gnt[2]`, `haddr`=0x012345 and `data_input`=0xBEEF one cycle after `req`. No further enable for CMD_GAP+1 cycles.
- Port 1 read with model returning 0xA55A: `rvalid[1]`=1 and `rdata`=0xA55A exactly RD_LATENCY cycles after `rd_enable`. No other `rvalid` bit set.
- All 4 ports requesting continuously from reset: grant order 0,1,2,3,0,1 with pulses spaced CMD_GAP+2 cycles.
- `busy` forced high for 20 cycles with port 3 requesting: no `gnt` until 1 cycle after `busy` falls.
- `rst` asserted 2 cycles after a read issue: no `rvalid`, FSM in ARB. Next request issues normally with `ptr` reset, so port 0 wins a tie.
